// File: rtl/rx_checker_if.sv
// -----------------------------------------------------------------------------
// rx_checker_if
// Groups the receive word stream and the checker's result signals.
//
//   i_rx_data / i_rx_ctrl   word stream into the checker (one word per cycle)
//   o_data / o_valid        extracted payload word
//   o_sof / o_eof           start / end of frame accepted (1-cycle pulses)
//   o_len_err               frame ended with the wrong payload word count
//   o_proto_err             word illegal for the current framing state
//   o_gap_err               START arrived before the minimum idle gap
//   o_frame_cnt / o_err_cnt saturating good / bad frame counters
//
// Modports:
//   slave  - the checker (consumes the stream, drives results)
//   master - the stream source / result observer
// -----------------------------------------------------------------------------
interface rx_checker_if #(
   parameter int DATA_WIDTH = 64
);
   logic [DATA_WIDTH-1:0] i_rx_data;
   logic                  i_rx_ctrl;
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_valid;
   logic                  o_sof;
   logic                  o_eof;
   logic                  o_len_err;
   logic                  o_proto_err;
   logic                  o_gap_err;
   logic [15:0]           o_frame_cnt;
   logic [15:0]           o_err_cnt;

   modport slave (
      input  i_rx_data, i_rx_ctrl,
      output o_data, o_valid, o_sof, o_eof, o_len_err, o_proto_err,
             o_gap_err, o_frame_cnt, o_err_cnt
   );

   modport master (
      output i_rx_data, i_rx_ctrl,
      input  o_data, o_valid, o_sof, o_eof, o_len_err, o_proto_err,
             o_gap_err, o_frame_cnt, o_err_cnt
   );
endinterface

// File: rtl/rx_checker.sv
// -----------------------------------------------------------------------------
// rx_checker
// Receive-side frame checker for the MII loopback path. Consumes a stream of
// idle / start / payload / EOF words, extracts payload words, checks frame
// length and framing order, and keeps saturating good/error frame counters.
//
// Ports:
//   clk    - clock, all logic on the rising edge
//   i_rst  - asynchronous active-high reset
//   bus    - rx_checker_if.slave: input word stream and all result outputs
//
// Optional feature macro: RX_CHECKER_GAP_CHECK_EN
//   When defined, a gap counter tracks idle words since the last frame end
//   and o_gap_err pulses (with o_sof) if a START arrives before IDLE_LENGTH
//   idles. When undefined, no gap counter exists and o_gap_err is 0.
//
// All outputs are registered: the response to an input word appears on the
// cycle after it is sampled.
// -----------------------------------------------------------------------------
module rx_checker #(
   parameter int         DATA_WIDTH  = 64,
   parameter int         DATA_LENGTH = 64,
   parameter int         IDLE_LENGTH = 16,
   parameter logic [7:0] IDLE_CODE   = 8'h07,
   parameter logic [7:0] START_CODE  = 8'hFB,
   parameter logic [7:0] EOF_CODE    = 8'hFD
) (
   input  logic         clk,
   input  logic         i_rst,
   rx_checker_if.slave  bus
);

   localparam int          EXP_WORDS   = DATA_LENGTH / (DATA_WIDTH / 8);
   localparam logic [15:0] EXP_WORDS_W = 16'(EXP_WORDS);
   localparam logic [15:0] CNT_MAX     = 16'hFFFF;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DATA = 1'b1
   } state_t;

   state_t                state_q,     state_d;
   logic [15:0]           word_cnt_q,  word_cnt_d;
   logic [DATA_WIDTH-1:0] data_q,      data_d;
   logic                  valid_q,     valid_d;
   logic                  sof_q,       sof_d;
   logic                  eof_q,       eof_d;
   logic                  len_err_q,   len_err_d;
   logic                  proto_err_q, proto_err_d;
   logic [15:0]           frame_cnt_q, frame_cnt_d;
   logic [15:0]           err_cnt_q,   err_cnt_d;

`ifdef RX_CHECKER_GAP_CHECK_EN
   // Wide enough to hold IDLE_LENGTH itself (the saturated value).
   localparam int                GAP_W   = (IDLE_LENGTH < 1) ? 1 : $clog2(IDLE_LENGTH + 1);
   localparam logic [GAP_W-1:0]  GAP_MAX = GAP_W'(IDLE_LENGTH);

   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             gap_err_q, gap_err_d;
`endif

   logic [7:0] code;
   assign code = bus.i_rx_data[7:0];

   // Saturating increments shared by the counters.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == CNT_MAX) ? v : v + 16'd1;
   endfunction

   // -------------------------------------------------------------------------
   // Next-state / output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      data_d      = data_q;       // o_data holds while no payload
      valid_d     = 1'b0;
      sof_d       = 1'b0;
      eof_d       = 1'b0;
      len_err_d   = 1'b0;
      proto_err_d = 1'b0;
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
`ifdef RX_CHECKER_GAP_CHECK_EN
      gap_cnt_d   = gap_cnt_q;
      gap_err_d   = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (!bus.i_rx_ctrl) begin
               // Payload outside a frame is discarded.
               proto_err_d = 1'b1;
            end else if (code == IDLE_CODE) begin
`ifdef RX_CHECKER_GAP_CHECK_EN
               if (gap_cnt_q != GAP_MAX) begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
`endif
            end else if (code == START_CODE) begin
               state_d    = ST_DATA;
               word_cnt_d = 16'd0;
               sof_d      = 1'b1;
`ifdef RX_CHECKER_GAP_CHECK_EN
               // Short gap is reported but the frame is still accepted.
               gap_err_d  = (gap_cnt_q < GAP_MAX);
`endif
            end else begin
               // EOF without a frame, or an unknown control code.
               proto_err_d = 1'b1;
            end
         end

         ST_DATA: begin
            if (!bus.i_rx_ctrl) begin
               data_d     = bus.i_rx_data;
               valid_d    = 1'b1;
               word_cnt_d = sat_inc16(word_cnt_q);
            end else if (code == EOF_CODE) begin
               state_d = ST_IDLE;
               eof_d   = 1'b1;
               if (word_cnt_q == EXP_WORDS_W) begin
                  frame_cnt_d = sat_inc16(frame_cnt_q);
               end else begin
                  len_err_d = 1'b1;
                  err_cnt_d = sat_inc16(err_cnt_q);
               end
`ifdef RX_CHECKER_GAP_CHECK_EN
               gap_cnt_d = '0;
`endif
            end else if (code == START_CODE) begin
               // Abort the current frame and immediately open a new one.
               proto_err_d = 1'b1;
               err_cnt_d   = sat_inc16(err_cnt_q);
               sof_d       = 1'b1;
               word_cnt_d  = 16'd0;
            end else begin
               // IDLE or unknown code mid-frame: abort back to IDLE, no EOF.
               proto_err_d = 1'b1;
               err_cnt_d   = sat_inc16(err_cnt_q);
               state_d     = ST_IDLE;
`ifdef RX_CHECKER_GAP_CHECK_EN
               gap_cnt_d   = '0;
`endif
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         word_cnt_q  <= 16'd0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         sof_q       <= 1'b0;
         eof_q       <= 1'b0;
         len_err_q   <= 1'b0;
         proto_err_q <= 1'b0;
         frame_cnt_q <= 16'd0;
         err_cnt_q   <= 16'd0;
      end else begin
         state_q     <= state_d;
         word_cnt_q  <= word_cnt_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         sof_q       <= sof_d;
         eof_q       <= eof_d;
         len_err_q   <= len_err_d;
         proto_err_q <= proto_err_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

`ifdef RX_CHECKER_GAP_CHECK_EN
   // Gap counter starts satisfied so the first frame after reset is clean.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         gap_cnt_q <= GAP_MAX;
         gap_err_q <= 1'b0;
      end else begin
         gap_cnt_q <= gap_cnt_d;
         gap_err_q <= gap_err_d;
      end
   end

   assign bus.o_gap_err = gap_err_q;
`else
   assign bus.o_gap_err = 1'b0;
`endif

   assign bus.o_data      = data_q;
   assign bus.o_valid     = valid_q;
   assign bus.o_sof       = sof_q;
   assign bus.o_eof       = eof_q;
   assign bus.o_len_err   = len_err_q;
   assign bus.o_proto_err = proto_err_q;
   assign bus.o_frame_cnt = frame_cnt_q;
   assign bus.o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_rx_checker.sv
// -----------------------------------------------------------------------------
// tb_rx_checker
// Scoreboard bench for rx_checker at default parameters. The driver applies
// one word per cycle on the falling edge and pushes the reference model's
// expected response; the monitor pops one expectation per rising edge (+1)
// and compares the whole output set. Directed test-plan sequences come first,
// followed by randomized frames and junk words.
// -----------------------------------------------------------------------------
module tb_rx_checker;

   localparam int EXP_WORDS  = 64 / 8;
   localparam int IDLE_LEN   = 16;
`ifdef RX_CHECKER_GAP_CHECK_EN
   localparam bit GAP_EN = 1'b1;
`else
   localparam bit GAP_EN = 1'b0;
`endif

   typedef struct packed {
      logic [63:0] data;
      logic        valid;
      logic        sof;
      logic        eof;
      logic        len_err;
      logic        proto_err;
      logic        gap_err;
      logic [15:0] frame_cnt;
      logic [15:0] err_cnt;
   } resp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   rx_checker_if #(.DATA_WIDTH(64)) rx_if ();

   rx_checker dut (
      .clk   (clk),
      .i_rst (rst),
      .bus   (rx_if.slave)
   );

   always #5 clk = ~clk;

   int    vectors     = 0;
   int    miscompares = 0;
   resp_t exp_q[$];

   // ---------------- reference model (frame-level view) ----------------
   bit          m_in_frame;
   int          m_words;
   int          m_frames;
   int          m_errs;
   int          m_idles;
   logic [63:0] m_last;

   task automatic model_reset();
      m_in_frame = 1'b0;
      m_words    = 0;
      m_frames   = 0;
      m_errs     = 0;
      m_idles    = IDLE_LEN;
      m_last     = '0;
   endtask

   task automatic model_step(input logic ctrl, input logic [63:0] w, output resp_t e);
      logic [7:0] c;
      c = w[7:0];
      e = '0;
      if (!m_in_frame) begin
         if (!ctrl)              e.proto_err = 1'b1;
         else if (c == 8'h07)    m_idles++;
         else if (c == 8'hFB) begin
            m_in_frame = 1'b1;
            m_words    = 0;
            e.sof      = 1'b1;
            e.gap_err  = GAP_EN && (m_idles < IDLE_LEN);
         end else                e.proto_err = 1'b1;
      end else begin
         if (!ctrl) begin
            m_words++;
            m_last  = w;
            e.valid = 1'b1;
         end else if (c == 8'hFD) begin
            e.eof      = 1'b1;
            m_in_frame = 1'b0;
            m_idles    = 0;
            if (m_words == EXP_WORDS) m_frames++;
            else begin
               e.len_err = 1'b1;
               m_errs++;
            end
         end else if (c == 8'hFB) begin
            e.proto_err = 1'b1;
            e.sof       = 1'b1;
            m_errs++;
            m_words     = 0;
         end else begin
            e.proto_err = 1'b1;
            m_errs++;
            m_in_frame  = 1'b0;
            m_idles     = 0;
         end
      end
      e.data      = m_last;
      e.frame_cnt = 16'((m_frames > 65535) ? 65535 : m_frames);
      e.err_cnt   = 16'((m_errs   > 65535) ? 65535 : m_errs);
   endtask

   // ---------------- driver helpers ----------------
   function automatic logic [63:0] ctl_word(input logic [7:0] code);
      logic [63:0] w;
      w      = {$urandom(), $urandom()};
      w[7:0] = code;
      return w;
   endfunction

   task automatic push_current();
      resp_t e;
      model_step(rx_if.i_rx_ctrl, rx_if.i_rx_data, e);
      exp_q.push_back(e);
   endtask

   task automatic send(input logic ctrl, input logic [63:0] w);
      @(negedge clk);
      rx_if.i_rx_ctrl = ctrl;
      rx_if.i_rx_data = w;
      push_current();
   endtask

   task automatic send_idles(input int n);
      for (int i = 0; i < n; i++) send(1'b1, ctl_word(8'h07));
   endtask

   task automatic send_frame(input int nwords, input logic [63:0] base);
      send(1'b1, ctl_word(8'hFB));
      for (int i = 0; i < nwords; i++) send(1'b0, base + 64'(i));
      send(1'b1, ctl_word(8'hFD));
   endtask

   function automatic resp_t sample();
      resp_t g;
      g.data      = rx_if.o_data;
      g.valid     = rx_if.o_valid;
      g.sof       = rx_if.o_sof;
      g.eof       = rx_if.o_eof;
      g.len_err   = rx_if.o_len_err;
      g.proto_err = rx_if.o_proto_err;
      g.gap_err   = rx_if.o_gap_err;
      g.frame_cnt = rx_if.o_frame_cnt;
      g.err_cnt   = rx_if.o_err_cnt;
      return g;
   endfunction

   task automatic report(input string name, input resp_t g, input resp_t e);
      $display("FAIL %s: got data=%h v=%b sof=%b eof=%b len=%b proto=%b gap=%b fc=%0d ec=%0d | exp data=%h v=%b sof=%b eof=%b len=%b proto=%b gap=%b fc=%0d ec=%0d",
               name, g.data, g.valid, g.sof, g.eof, g.len_err, g.proto_err, g.gap_err, g.frame_cnt, g.err_cnt,
               e.data, e.valid, e.sof, e.eof, e.len_err, e.proto_err, e.gap_err, e.frame_cnt, e.err_cnt);
   endtask

   // Asserts reset away from the clock edge, checks that every output has
   // cleared immediately, then releases it on the next falling edge.
   task automatic do_reset();
      resp_t g;
      @(negedge clk);
      rx_if.i_rx_ctrl = 1'b1;
      rx_if.i_rx_data = ctl_word(8'h07);
      rst = 1'b1;
      #1;
      g = sample();
      vectors++;
      if (g !== '0) begin
         miscompares++;
         report("async_reset", g, '0);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      push_current();
   endtask

   // ---------------- monitor ----------------
   int txn = 0;
   initial begin
      resp_t g, e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = sample();
            vectors++;
            txn++;
            if (g !== e) begin
               miscompares++;
               report($sformatf("txn%0d", txn), g, e);
            end else begin
               $display("txn%0d ok: v=%b sof=%b eof=%b len=%b proto=%b gap=%b fc=%0d ec=%0d",
                        txn, g.valid, g.sof, g.eof, g.len_err, g.proto_err, g.gap_err, g.frame_cnt, g.err_cnt);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rx_if.i_rx_ctrl = 1'b1;
      rx_if.i_rx_data = 64'h07;
      model_reset();

      do_reset();

      // Good frame with payload 0..7 after a full idle gap.
      send_idles(16);
      send_frame(8, 64'd0);
      send_idles(16);

      // Short frame: length error.
      send_frame(7, 64'h100);
      send_idles(16);

      // Payload word and EOF while idle: protocol errors only.
      send(1'b0, 64'hDEAD_BEEF_0000_0001);
      send(1'b1, ctl_word(8'hFD));
      send_idles(16);

      // START mid-frame aborts and restarts.
      send(1'b1, ctl_word(8'hFB));
      for (int i = 0; i < 3; i++) send(1'b0, 64'h200 + 64'(i));
      send_frame(8, 64'h300);

      // Short idle gap before the next START.
      send_idles(3);
      send_frame(8, 64'h400);
      send(1'b1, ctl_word(8'hFB));   // zero-gap START straight after EOF
      send_frame(8, 64'h480);        // aborted by this START, then a good frame
      send_idles(16);

      // Reset after the 4th payload word, then a clean frame.
      send(1'b1, ctl_word(8'hFB));
      for (int i = 0; i < 4; i++) send(1'b0, 64'h500 + 64'(i));
      do_reset();
      send_idles(16);
      send_frame(8, 64'h600);

      // Empty frame.
      send_idles(16);
      send_frame(0, 64'h0);

      // Randomized traffic.
      for (int it = 0; it < 300; it++) begin
         int kind;
         kind = int'($urandom_range(0, 9));
         if (kind <= 6) begin
            int n, term;
            send_idles(int'($urandom_range(0, 18)));
            send(1'b1, ctl_word(8'hFB));
            n = int'($urandom_range(6, 10));
            for (int i = 0; i < n; i++) send(1'b0, {$urandom(), $urandom()});
            term = int'($urandom_range(0, 9));
            if (term <= 6)      send(1'b1, ctl_word(8'hFD));
            else if (term == 7) send(1'b1, ctl_word(8'hFB));
            else if (term == 8) send(1'b1, ctl_word(8'h07));
            else                send(1'b1, ctl_word(8'($urandom())));
         end else if (kind == 7) begin
            send(1'b0, {$urandom(), $urandom()});
         end else begin
            send(1'b1, ctl_word(8'($urandom())));
         end
      end
      send_idles(4);

      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending responses, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout: got no end of run, expected $finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rx_checker.md
# rx_checker

Receive-side frame checker for the 1.6T MII loopback path. It consumes the 64-bit data / 1-bit control word stream produced by the frame generator, a repeating sequence of idle, start, payload and EOF words. It extracts payload words and validates frame length and framing order. It also keeps saturating good-frame and error counters for the bench and downstream logic.

## Interface

Parameters:
- DATA_WIDTH, 64, word width in bits; a multiple of 8.
- DATA_LENGTH, 64, expected payload bytes per frame; a multiple of DATA_WIDTH/8. Expected word count EXP_WORDS = DATA_LENGTH/(DATA_WIDTH/8), which is 8 at the defaults.
- IDLE_LENGTH, 16, minimum idle words between EOF and the next START.
- IDLE_CODE, 8'h07, control code for idle.
- START_CODE, 8'hFB, control code for start of frame.
- EOF_CODE, 8'hFD, control code for end of frame.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset, asynchronous and active-high.
- i_rx_data  in  DATA_WIDTH  input word.
- i_rx_ctrl  in  1  1 = control word. The code is i_rx_data[7:0]; the upper bytes are ignored.
- o_data  out  DATA_WIDTH  payload word.
- o_valid  out  1  o_data holds payload.
- o_sof  out  1  pulse: START accepted.
- o_eof  out  1  pulse: EOF accepted.
- o_len_err  out  1  pulse with o_eof when the payload word count is not EXP_WORDS.
- o_proto_err  out  1  pulse on an illegal word for the current state.
- o_gap_err  out  1  pulse: START arrived before IDLE_LENGTH idles.
- o_frame_cnt  out  16  good frames, saturating at 16'hFFFF.
- o_err_cnt  out  16  bad or aborted frames, saturating at 16'hFFFF.

## Operation

- There is one input word per cycle and no backpressure. Every cycle's input is evaluated.
- FSM states are IDLE and DATA. Reset state is IDLE.
- In IDLE:
  - ctrl=1 with IDLE_CODE: stay in IDLE.
  - ctrl=1 with START_CODE: go to DATA, clear the word count, pulse o_sof.
  - ctrl=0: pulse o_proto_err, word discarded, stay in IDLE.
  - ctrl=1 with EOF_CODE or an unknown code: pulse o_proto_err, stay in IDLE.
  - No counter changes in IDLE.
- In DATA:
  - ctrl=0: o_data = i_rx_data, o_valid=1, word count +1. The word count is 16 bits and saturates.
  - EOF_CODE: pulse o_eof and return to IDLE. If count == EXP_WORDS, o_frame_cnt +1. Otherwise pulse o_len_err and o_err_cnt +1.
  - START_CODE: pulse o_proto_err, o_err_cnt +1, and abort the frame. A new frame starts immediately: pulse o_sof, clear the count, stay in DATA.
  - IDLE_CODE or an unknown code: pulse o_proto_err, o_err_cnt +1, go to IDLE. No o_eof.
- The START and EOF words carry no payload. A frame with zero payload words followed by EOF is a length error when EXP_WORDS > 0.
- The idle-gap check is described in Configuration.

## Timing

- All outputs are registered, with 1-cycle latency from the input word to its response.
- Reset values are all 0: o_data, o_valid, o_sof, o_eof, all error pulses, both counters, word count, FSM = IDLE.
- Reset asserted mid-frame discards the frame immediately. No o_eof or error is reported and the counters clear.
- Pulses (o_sof, o_eof, o_len_err, o_proto_err, o_gap_err) last exactly 1 cycle per triggering word.
- o_data holds its last value while o_valid=0.
- Counter increments are visible on the cycle after the EOF or abort word, coincident with the related pulse.
- Both counters hold at 16'hFFFF with no wrap. Error pulses still fire when saturated.
- Back-to-back EOF then START (zero idle gap) is accepted as framing. Only the optional gap check flags it.

## Configuration

- Macro RX_CHECKER_GAP_CHECK_EN.
- When defined:
  - A gap counter clears on EOF and on abort-to-IDLE.
  - It increments on each IDLE_CODE word while in IDLE and saturates at IDLE_LENGTH.
  - A START seen while gap < IDLE_LENGTH pulses o_gap_err together with o_sof. The frame is still accepted and o_err_cnt is not incremented.
  - After reset the gap counter is preset to IDLE_LENGTH (satisfied).
- When undefined: no gap counter is built and o_gap_err is tied to 0.

## Test plan

- 16 idles, START, 8 data words 0..7, EOF, all at defaults:
  - o_sof is seen once.
  - o_valid is seen 8 times, with o_data 0..7 in order.
  - o_eof is seen once with o_len_err=0.
  - o_frame_cnt=1, o_err_cnt=0.
- START, 7 data words, EOF: o_eof with o_len_err=1, o_err_cnt=1, o_frame_cnt=0.
- A data word (ctrl=0) and an EOF word in IDLE: two o_proto_err pulses, no o_valid, counters unchanged.
- START, 3 data words, START, 8 data words, EOF:
  - o_proto_err=1 and a second o_sof on the cycle after the second START.
  - Final state: o_err_cnt=1, o_frame_cnt=1.
- With RX_CHECKER_GAP_CHECK_EN: a good frame, 3 idles, START, 8 data words, EOF. o_gap_err=1 with the second o_sof, and o_frame_cnt=2. Without the macro, o_gap_err stays 0.
- i_rst asserted after the 4th data word of a frame:
  - All outputs are 0 in the same cycle.
  - A following good frame gives o_frame_cnt=1 and o_err_cnt=0.
